// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-stage types and constants
package if_fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0]    PC_INC   = 16'h0002;
    localparam logic [INSTR_W-1:0] NOP      = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - single-outstanding instruction fetch with 1-entry output buffer
module if_fetch_unit #(
    parameter int                  PC_W     = if_fetch_unit_pkg::PC_W,
    parameter int                  INSTR_W  = if_fetch_unit_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     RESET_PC = if_fetch_unit_pkg::RESET_PC,
    parameter logic [PC_W-1:0]     PC_INC   = if_fetch_unit_pkg::PC_INC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   im_req,
    output logic [PC_W-1:0]        im_addr,
    input  logic                   im_gnt,
    input  logic                   im_rvalid,
    input  logic [INSTR_W-1:0]     im_rdata,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [PC_W-1:0]        next_pc,
    output logic                   instr_valid,
    output logic [PC_W-1:0]        fetch_pc
);
    import if_fetch_unit_pkg::*;

    fetch_state_e           state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [PC_W-1:0]        pend_q, pend_d;
    logic [PC_W-1:0]        npc_q, npc_d;
    logic [INSTR_W-1:0]     instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   consume;
    logic                   can_issue;
    logic                   issue;

    assign consume   = valid_q & ~stall;
    assign can_issue = ~valid_q | consume;
    // A new fetch only starts when the buffer will have room for its response.
    assign im_req    = (state_q == FS_IDLE) & can_issue & ~redirect & reset;
    assign issue     = im_req & im_gnt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        if (consume) begin
            valid_d = 1'b0;
        end
        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end

        case (state_q)
            FS_IDLE: begin
                if (issue) begin
                    pc_d    = pc_q + PC_INC;
                    pend_d  = pc_q + PC_INC;
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (im_rvalid) begin
                    state_d = FS_IDLE;
                    if (!redirect) begin
                        instr_d = im_rdata;
                        npc_d   = pend_q;
                        valid_d = 1'b1;
                    end
                end else if (redirect) begin
                    state_d = FS_DROP;
                end
            end
            FS_DROP: begin
                if (im_rvalid) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            npc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign im_addr     = pc_q;
    assign fetch_pc    = pc_q;
    assign instr_out   = instr_q;
    assign next_pc     = npc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized checks of if_fetch_unit against a transaction model
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, im_gnt, im_rvalid;
    logic [15:0] redirect_pc, im_rdata;
    logic        im_req, instr_valid;
    logic [15:0] im_addr, instr_out, next_pc, fetch_pc;

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_gnt      (im_gnt),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .instr_out   (instr_out),
        .next_pc     (next_pc),
        .instr_valid (instr_valid),
        .fetch_pc    (fetch_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: program counter, an optional in-flight fetch (with a
    // squashed flag) and the visible buffer contents.
    logic [15:0] m_pc, m_pend, m_bd, m_bn;
    logic        m_out, m_sq, m_bv;

    logic        obs_req;
    logic [15:0] obs_addr;
    logic        granted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_pend = '0; m_bd = '0; m_bn = '0;
        m_out = 1'b0; m_sq = 1'b0; m_bv = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model at posedge.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                       input logic g, input logic v, input logic [15:0] dat);
        logic exp_req, nbv;
        reset = r; stall = s; redirect = rd; redirect_pc = rp;
        im_gnt = g; im_rvalid = v; im_rdata = dat;
        #1;
        exp_req = r && !m_out && !rd && (!m_bv || !s);
        chk("im_req", im_req, exp_req);
        chk("im_addr", im_addr, m_pc);
        chk("fetch_pc", fetch_pc, m_pc);
        chk("instr_valid", instr_valid, m_bv);
        chk("instr_out", instr_out, m_bd);
        chk("next_pc", next_pc, m_bn);
        obs_req  = im_req;
        obs_addr = im_addr;
        granted  = exp_req && g;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            nbv = m_bv && s;
            if (rd) begin
                m_pc = rp;
                nbv  = 1'b0;
            end
            if (m_out) begin
                if (v) begin
                    if (!m_sq && !rd) begin
                        m_bd = dat; m_bn = m_pend; nbv = 1'b1;
                    end
                    m_out = 1'b0; m_sq = 1'b0;
                end else if (rd) begin
                    m_sq = 1'b1;
                end
            end else if (granted) begin
                m_pc   = m_pc + 16'h0002;
                m_pend = m_pc;
                m_out  = 1'b1;
            end
            m_bv = nbv;
        end
        @(negedge clk);
    endtask

    int          mem_busy, mem_lat;
    logic [15:0] mem_data;
    logic        rv;
    logic [15:0] rdat;

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Sequential fetch with single-cycle memory latency.
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", fetch_pc, 16'h0000);
        chk("rst_instr", instr_out, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("seq_addr0", obs_addr, 16'h0000);
        chk("seq_gnt0", granted, 1);
        cyc(1, 0, 0, 0, 1, 1, 16'hA001);
        chk("seq_i0", instr_out, 16'hA001);
        chk("seq_n0", next_pc, 16'h0002);
        chk("seq_v0", instr_valid, 1);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("seq_addr1", obs_addr, 16'h0002);
        chk("seq_v0_off", instr_valid, 0);
        cyc(1, 0, 0, 0, 1, 1, 16'hA002);
        chk("seq_i1", instr_out, 16'hA002);
        chk("seq_n1", next_pc, 16'h0004);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("seq_addr2", obs_addr, 16'h0004);

        // Buffer holds under stall; request resumes the cycle stall drops.
        cyc(1, 1, 0, 0, 1, 1, 16'hB0B0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 1, 0, 0);
            chk("stall_req", obs_req, 0);
            chk("stall_instr", instr_out, 16'hB0B0);
            chk("stall_npc", next_pc, 16'h0006);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("unstall_req", obs_req, 1);

        // Redirect while waiting; late response must be discarded.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 16'h0100, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("drop_noreq", obs_req, 0);
        cyc(1, 0, 0, 0, 1, 1, 16'hDEAD);
        chk("drop_valid", instr_valid, 0);
        chk("drop_instr", instr_out, 16'h0000);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("drop_addr", obs_addr, 16'h0100);

        // Redirect coinciding with the response.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 16'h0200, 1, 1, 16'h1234);
        chk("same_valid", instr_valid, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("same_req", obs_req, 1);
        chk("same_addr", obs_addr, 16'h0200);

        // Latest of two redirects while dropping wins.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 16'h0300, 1, 0, 0);
        cyc(1, 0, 1, 16'h0400, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 16'h5555);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("dbl_addr", obs_addr, 16'h0400);

        // Reset with a valid buffer, then in WAIT, then a stray response.
        cyc(1, 0, 0, 0, 1, 1, 16'h7777);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("rstb_valid_pre", instr_valid, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rstb_valid", instr_valid, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rstw_req", obs_req, 0);
        chk("rstw_valid", instr_valid, 0);
        chk("rstw_pc", fetch_pc, 16'h0000);
        cyc(1, 1, 0, 0, 0, 1, 16'hEEEE);
        chk("stray_valid", instr_valid, 0);
        chk("stray_instr", instr_out, 16'h0000);

        // PC wrap-around.
        cyc(1, 0, 1, 16'hFFFE, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("wrap_addr", obs_addr, 16'hFFFE);
        chk("wrap_pc", fetch_pc, 16'h0000);
        cyc(1, 0, 0, 0, 0, 1, 16'hC0DE);
        chk("wrap_npc", next_pc, 16'h0000);

        // Randomized traffic with a variable-latency memory.
        cyc(0, 0, 0, 0, 0, 0, 0);
        mem_busy = 0; mem_lat = 0; mem_data = '0;
        for (int i = 0; i < 4000; i++) begin
            logic        r_r, r_s, r_rd, r_g;
            logic [15:0] r_rp;
            r_r  = ($urandom_range(0, 299) != 0);
            r_s  = ($urandom_range(0, 3) == 0);
            r_rd = ($urandom_range(0, 9) == 0);
            r_rp = 16'($urandom) & 16'hFFFE;
            r_g  = ($urandom_range(0, 2) != 0);
            rv   = 1'b0;
            rdat = 16'($urandom);
            if (mem_busy != 0 && mem_lat == 0) begin
                rv   = 1'b1;
                rdat = mem_data;
            end else if (mem_busy == 0 && $urandom_range(0, 19) == 0) begin
                rv = 1'b1;
            end
            cyc(r_r, r_s, r_rd, r_rp, r_g, rv, rdat);
            if (!r_r) begin
                mem_busy = 0;
            end else if (granted) begin
                mem_busy = 1;
                mem_lat  = $urandom_range(0, 3);
                mem_data = 16'($urandom);
            end else if (rv) begin
                mem_busy = 0;
            end else if (mem_busy != 0) begin
                mem_lat--;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
